// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down counter with wrap or saturate
// behaviour at the 0 / MAX_VALUE boundaries, synchronous clear and load,
// a registered terminal-count pulse and a sticky overflow flag.
//
// Optional build macro: PARAM_COUNTER_PRESCALE_EN
//   Defined   - a prescaler gates steps to one per PRESCALE_DIV enabled cycles.
//   Undefined - every enabled cycle is a step; PRESCALE_DIV is ignored.
//
// Synchronous priority on each posedge: clear > load > step > hold.
module param_updown_counter #(
    parameter int WIDTH        = 4,
    parameter int MAX_VALUE    = (1 << WIDTH) - 1,
    parameter int RESET_VALUE  = 0,
    parameter bit SATURATE     = 1'b0,
    parameter int PRESCALE_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero,
    output logic             overflow
);

    // Terminal value held one bit wider so the up step can be compared
    // against it before truncation (no natural wrap at 2^WIDTH).
    localparam logic [WIDTH:0]   MAX_EXT   = MAX_VALUE[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_NARROW = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_NARROW = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH-1:0] next_step;
    logic [WIDTH-1:0] load_clamped;
    logic             boundary;
    logic             step_fire;
    logic             unused_ok;

`ifdef PARAM_COUNTER_PRESCALE_EN
    localparam int             PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0] prescale_cnt;

    // A step happens only on the enabled cycle that closes a prescale period.
    assign step_fire = enable && (prescale_cnt == PS_LAST);

    // Prescaler counts enabled cycles; holds when disabled, restarts on clear/load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_cnt <= '0;
        end else if (clear || load) begin
            prescale_cnt <= '0;
        end else if (enable) begin
            prescale_cnt <= step_fire ? '0 : prescale_cnt + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign step_fire       = enable;
    assign unused_prescale = (PRESCALE_DIV > 0);
`endif

    // Next count for a step in the sampled direction, plus boundary detection.
    always_comb begin
        count_ext = {1'b0, count};
        step_ext  = count_ext;
        boundary  = 1'b0;
        if (up_down) begin
            step_ext = count_ext + 1'b1;
            if (step_ext > MAX_EXT) begin
                boundary = 1'b1;
                step_ext = SATURATE ? count_ext : '0;
            end
        end else begin
            if (count_ext == '0) begin
                boundary = 1'b1;
                step_ext = SATURATE ? count_ext : MAX_EXT;
            end else begin
                step_ext = count_ext - 1'b1;
            end
        end
        next_step = step_ext[WIDTH-1:0];
    end

    // Loaded values above the terminal value are clamped to it.
    always_comb begin
        load_clamped = load_value;
        if ({1'b0, load_value} > MAX_EXT) begin
            load_clamped = MAX_NARROW;
        end
    end

    // The top bit of step_ext is always zero once the boundary is resolved.
    assign unused_ok = step_ext[WIDTH];

    // Count, terminal-count pulse and sticky overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= RST_NARROW;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            count    <= load_clamped;
            tc       <= 1'b0;
        end else if (step_fire) begin
            count    <= next_step;
            tc       <= boundary;
            overflow <= overflow | boundary;
        end else begin
            tc       <= 1'b0;
        end
    end

    assign at_max  = (count == MAX_NARROW);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a wrap-mode and a saturate-mode instance
// share one stimulus stream and are compared every cycle against an
// arithmetic reference model of the counting rules.
module tb_param_updown_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int RSTV = 0;
    localparam int DIV  = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         enable;
    logic         up_down;

    logic [W-1:0] w_count, s_count;
    logic         w_tc, w_at_max, w_at_zero, w_ovf;
    logic         s_tc, s_at_max, s_at_zero, s_ovf;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_wcnt, m_scnt, m_ps;
    bit m_wtc, m_stc, m_wovf, m_sovf;

    param_updown_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .RESET_VALUE(RSTV),
                           .SATURATE(1'b0), .PRESCALE_DIV(DIV)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .count(w_count), .tc(w_tc), .at_max(w_at_max), .at_zero(w_at_zero),
        .overflow(w_ovf));

    param_updown_counter #(.WIDTH(W), .MAX_VALUE(MAXV), .RESET_VALUE(RSTV),
                           .SATURATE(1'b1), .PRESCALE_DIV(DIV)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up_down(up_down),
        .count(s_count), .tc(s_tc), .at_max(s_at_max), .at_zero(s_at_zero),
        .overflow(s_ovf));

    // Clock
    always #5 clk = ~clk;

    // One boundary-aware step of the counting rules, in plain integers.
    task automatic step_one(input bit sat, input int cnt_in, input bit up,
                            output int cnt_out, output bit hit);
        int nxt;
        nxt = up ? cnt_in + 1 : cnt_in - 1;
        hit = (nxt > MAXV) || (nxt < 0);
        if (!hit)          cnt_out = nxt;
        else if (sat)      cnt_out = cnt_in;
        else if (nxt < 0)  cnt_out = MAXV;
        else               cnt_out = 0;
    endtask

    task automatic model_reset();
        m_wcnt = RSTV; m_scnt = RSTV; m_ps = 0;
        m_wtc = 0; m_stc = 0; m_wovf = 0; m_sovf = 0;
    endtask

    // Model effect of one rising edge with the currently driven inputs.
    task automatic model_edge();
        bit fire;
        bit hit;
        if (!reset_n) begin
            model_reset();
        end else if (clear) begin
            m_wcnt = 0; m_scnt = 0; m_wtc = 0; m_stc = 0;
            m_wovf = 0; m_sovf = 0; m_ps = 0;
        end else if (load) begin
            m_wcnt = (int'(load_value) > MAXV) ? MAXV : int'(load_value);
            m_scnt = m_wcnt;
            m_wtc = 0; m_stc = 0; m_ps = 0;
        end else if (enable) begin
`ifdef PARAM_COUNTER_PRESCALE_EN
            fire = (m_ps == DIV - 1);
            m_ps = fire ? 0 : m_ps + 1;
`else
            fire = 1'b1;
`endif
            if (fire) begin
                step_one(1'b0, m_wcnt, up_down, m_wcnt, hit);
                m_wtc = hit; m_wovf = m_wovf | hit;
                step_one(1'b1, m_scnt, up_down, m_scnt, hit);
                m_stc = hit; m_sovf = m_sovf | hit;
            end else begin
                m_wtc = 0; m_stc = 0;
            end
        end else begin
            m_wtc = 0; m_stc = 0;
        end
    endtask

    function automatic logic [15:0] exp_vec();
        return {4'(m_wcnt), m_wtc, m_wovf, m_wcnt == MAXV, m_wcnt == 0,
                4'(m_scnt), m_stc, m_sovf, m_scnt == MAXV, m_scnt == 0};
    endfunction

    function automatic logic [15:0] obs_vec();
        return {w_count, w_tc, w_ovf, w_at_max, w_at_zero,
                s_count, s_tc, s_ovf, s_at_max, s_at_zero};
    endfunction

    // Driver: advance one clock with current inputs; sample 1ns after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clear = 0; load = 0; load_value = '0; enable = 0; up_down = 1;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 0;
        model_reset();
        #1;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_async got=%h exp=%h", obs_vec(), exp_vec());
        end
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_hold got=%h exp=%h", obs_vec(), exp_vec());
        end
        reset_n = 1;
    endtask

    task automatic test_up_wrap();
        enable = 1; up_down = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL up_wrap[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        set_idle();
    endtask

    task automatic test_down_wrap_clear();
        load_value = 0; load = 1;
        tick();
        load = 0; enable = 1; up_down = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL down_wrap[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        enable = 0; clear = 1;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL clear got=%h exp=%h", obs_vec(), exp_vec());
        end
        set_idle();
    endtask

    task automatic test_saturate();
        load_value = 8; load = 1;
        tick();
        load = 0; enable = 1; up_down = 1;
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL sat_up[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        enable = 0; load_value = 0; load = 1;
        tick();
        load = 0; enable = 1; up_down = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL sat_down[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        set_idle();
    endtask

    task automatic test_priority_clamp();
        load_value = 5; clear = 1; load = 1; enable = 1;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL prio_clear got=%h exp=%h", obs_vec(), exp_vec());
        end
        clear = 0; load_value = 15; load = 1; enable = 1; up_down = 1;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL load_clamp got=%h exp=%h", obs_vec(), exp_vec());
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        // Set overflow first, then park the count at 6.
        load_value = 9; load = 1;
        tick();
        load = 0; enable = 1; up_down = 1;
        repeat (DIV) tick();
        enable = 0; load_value = 6; load = 1;
        tick();
        load = 0;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL pre_reset got=%h exp=%h", obs_vec(), exp_vec());
        end
        enable = 1;
        #3;
        reset_n = 0;
        model_reset();
        #1;
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        reset_n = 1;
        set_idle();
    endtask

    task automatic test_enable_gap();
        clear = 1;
        tick();
        clear = 0; up_down = 1;
        for (int i = 0; i < 12; i++) begin
            enable = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL enable_gap[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear      = ($urandom_range(0, 31) == 0);
            load       = ($urandom_range(0, 15) == 0);
            load_value = W'($urandom_range(0, 15));
            enable     = ($urandom_range(0, 3) != 0);
            up_down    = ($urandom_range(0, 2) != 0) ^ (i >= 200);
            tick();
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d] got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap_clear();
        test_saturate();
        test_priority_clamp();
        test_async_reset();
        test_enable_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
